if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Emits one registered, fetched instruction per cycle to the IF/ID register, or a zero-word bubble when nothing is fetched.
- Handles downstream stall (buffers one fetched instruction) and branch redirects from EX, including discarding an in-flight fetch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  downstream hold request from pipeline control; no new instruction may be emitted while high
- branch_flag  in  1  redirect request from EX, single-cycle pulse
- branch_target  in  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0
- mem_req  out  1  fetch request, held high until mem_ack
- mem_addr  out  ADDR_W  fetch address; stable while mem_req is high
- mem_ack  in  1  response valid; may be high in the same cycle mem_req rises
- mem_rdata  in  INST_W  instruction word, valid when mem_ack=1
- if_pc  out  ADDR_W  registered PC of emitted instruction
- if_inst  out  INST_W  registered instruction; 0 when if_valid=0
- if_valid  out  1  registered; 1 for exactly one cycle per emitted instruction
- stallreq  out  1  combinational; 1 when no instruction is available this cycle because memory has not responded

Behaviour:
- Registers:
  - state ∈ {REQ, DROP, HOLD}
  - req_addr: the outstanding or next fetch address
  - tgt: pending redirect address
  - buf_pc, buf_inst: single-entry buffer
- Reset, applied at the clk edge with rst=1 and taking priority over all other inputs:
  - state=REQ, req_addr=RESET_PC
  - if_pc=0, if_inst=0, if_valid=0, buffer cleared
  - mem_req is forced to 0 while rst=1
  - Reset mid-fetch abandons the outstanding request; memory must tolerate the dropped request.
- Output decode:
  - mem_req=1 in REQ and DROP, 0 in HOLD.
  - mem_addr=req_addr.
  - stallreq = (state==DROP) | (state==REQ & ~mem_ack).
- Default each cycle: if_valid<=0, if_inst<=0, if_pc<=0, unless an emit occurs.
- An emit sets if_pc/if_inst/if_valid on the next edge, so latency is 1 cycle from the ack cycle. An ack every cycle sustains 1 instruction/cycle.
- REQ transitions, in priority order (branch > ack > stall):
  - branch_flag & mem_ack: discard rdata; req_addr<=target; stay REQ.
  - branch_flag & ~mem_ack: tgt<=target; go DROP.
  - mem_ack & ~stall: emit (req_addr, mem_rdata); req_addr<=req_addr+4; stay REQ.
  - mem_ack & stall: buf<=(req_addr, mem_rdata); go HOLD; no emit.
  - ~mem_ack: wait in REQ; stall has no effect.
- DROP: the old request stays on the bus with its address unchanged until ack.
  - branch_flag: tgt<=new target (last redirect wins).
  - mem_ack: discard rdata; req_addr<=tgt, or the new target if branch_flag is high the same cycle; go REQ.
  - Never emits.
- HOLD:
  - branch_flag: drop buffer; req_addr<=target; go REQ; no emit.
  - ~stall: emit buffer; req_addr<=buf_pc+4; go REQ.
  - stall: remain in HOLD.
- PC arithmetic: modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 wraps to 0.
- Only one request is ever outstanding; there is no speculative prefetch.

Test Plan:
1. Release reset; zero-latency memory with ack=1 every cycle, rdata=addr^32'hA5A5_0000. Required response: mem_addr 0,4,8,C on consecutive cycles; if_valid=1 with if_pc 0,4,8,C one cycle after each; stallreq=0 throughout.
2. Memory acks 3 cycles after req, with req at addr 0x10. Required response: mem_addr held at 0x10 and stallreq=1 for 3 cycles; if_pc=0x10, if_valid=1 for one cycle only; next mem_addr=0x14.
3. Ack for 0x20 arrives with stall=1, and stall is held 4 cycles. Required response: mem_req=0 and if_valid=0 during the hold; one cycle after stall falls, if_pc=0x20 is emitted once; then mem_addr=0x24.
4. branch_flag with target 0x103 one cycle after req 0x30 is issued, ack arriving 2 cycles later. Required response: 0x30 data is never emitted; mem_addr=0x30 holds until its ack, then becomes 0x100; the next emitted if_pc=0x100.
5. branch_flag with target 0x200 in the same cycle as ack+stall for 0x40. Required response: nothing is buffered and no HOLD is entered; next mem_addr=0x200.
6. Assert rst for 1 cycle while in DROP and while in HOLD. Required response: the next cycle shows mem_addr=RESET_PC, all if_* outputs 0, and the pending target/buffer never appear at the outputs.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
// master: mem_req/mem_addr out, mem_ack/mem_rdata in; slave is the mirror.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I fetch stage: owns the PC, fetches over mem (req/ack), emits to IF/ID.
// Ports: clk, rst, stall, branch_flag/target in; mem bus; if_pc/inst/valid, stallreq out.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  if_fetch_if.master        mem,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid,
  output logic              stallreq
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] req_addr, req_n;
  logic [ADDR_W-1:0] tgt, tgt_n;
  logic [ADDR_W-1:0] buf_pc, bpc_n;
  logic [INST_W-1:0] buf_inst, binst_n;
  logic              emit;
  logic [ADDR_W-1:0] epc;
  logic [INST_W-1:0] einst;
  logic [ADDR_W-1:0] target;

  // Redirects are always word aligned.
  assign target = branch_target & ~ADDR_W'(3);

  // Reset abandons any outstanding request immediately.
  assign mem.mem_req  = ~rst & (state != HOLD);
  assign mem.mem_addr = req_addr;
  assign stallreq     = (state == DROP) |
                        ((state == REQ) & ~mem.mem_ack);

  always_comb begin
    state_n = state;
    req_n   = req_addr;
    tgt_n   = tgt;
    bpc_n   = buf_pc;
    binst_n = buf_inst;
    emit    = 1'b0;
    epc     = req_addr;
    einst   = mem.mem_rdata;
    unique case (state)
      REQ: begin
        if (branch_flag) begin
          if (mem.mem_ack) begin
            req_n = target;
          end else begin
            tgt_n   = target;
            state_n = DROP;
          end
        end else if (mem.mem_ack) begin
          if (!stall) begin
            emit  = 1'b1;
            req_n = req_addr + ADDR_W'(4);
          end else begin
            bpc_n   = req_addr;
            binst_n = mem.mem_rdata;
            state_n = HOLD;
          end
        end
      end
      DROP: begin
        // Old request stays on the bus; its data is thrown away.
        if (branch_flag) tgt_n = target;
        if (mem.mem_ack) begin
          req_n   = branch_flag ? target : tgt;
          state_n = REQ;
        end
      end
      HOLD: begin
        if (branch_flag) begin
          bpc_n   = '0;
          binst_n = '0;
          req_n   = target;
          state_n = REQ;
        end else if (!stall) begin
          emit    = 1'b1;
          epc     = buf_pc;
          einst   = buf_inst;
          req_n   = buf_pc + ADDR_W'(4);
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      req_addr <= RESET_PC;
      tgt      <= '0;
      buf_pc   <= '0;
      buf_inst <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_n;
      req_addr <= req_n;
      tgt      <= tgt_n;
      buf_pc   <= bpc_n;
      buf_inst <= binst_n;
      if_valid <= emit;
      if_pc    <= emit ? epc : '0;
      if_inst  <= emit ? einst : '0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, slow memory, stall, redirects,
// mid-fetch reset and PC wrap.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, bf, ack;
  logic [31:0] tgt;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, stallreq;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [98:0] e;

  if_fetch_if mb ();

  assign mb.mem_ack   = ack;
  assign mb.mem_rdata = mb.mem_addr ^ 32'hA5A5_0000;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (bf),
    .branch_target (tgt),
    .mem           (mb),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid),
    .stallreq      (stallreq)
  );

  always #5 clk = ~clk;

  wire [98:0] obs = {mb.mem_req, mb.mem_addr, stallreq,
                     if_valid, if_pc, if_inst};

  // Expected {mem_req, mem_addr, stallreq, if_valid, if_pc, if_inst}.
  function automatic logic [98:0] ev(int r, logic [31:0] a, int s,
                                     int v, logic [31:0] p);
    logic [31:0] pc, in;
    pc = v[0] ? p : 32'h0;
    in = v[0] ? (p ^ 32'hA5A5_0000) : 32'h0;
    return {r[0], a, s[0], v[0], pc, in};
  endfunction

  // Inputs change just after negedge; checks follow 1ns later.
  task automatic step(int r, int a, int s, int b, logic [31:0] t);
    @(negedge clk);
    rst = r[0]; ack = a[0]; stall = s[0]; bf = b[0]; tgt = t;
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_cmp++; e = ev(0, 0, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL reset got %h exp %h", obs, e); end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      n_cmp++; e = ev(1, 32'(4 * i), 0, (i > 0) ? 1 : 0, 32'(4 * i - 4));
      if (obs !== e) begin n_bad++; $display("FAIL stream%0d got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_slow_mem;
    for (int w = 0; w < 3; w++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++; e = ev(1, 32'h10, 1, (w == 0) ? 1 : 0, 32'hC);
      if (obs !== e) begin n_bad++; $display("FAIL slow_wait%0d got %h exp %h", w, obs, e); end
    end
    step(0, 1, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h10, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL slow_ack got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h14, 1, 1, 32'h10);
    if (obs !== e) begin n_bad++; $display("FAIL slow_emit got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h14, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL slow_once got %h exp %h", obs, e); end
  endtask

  task automatic test_stall_hold;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    n_cmp++; e = ev(1, 32'h20, 0, 1, 32'h1C);
    if (obs !== e) begin n_bad++; $display("FAIL hold_ack got %h exp %h", obs, e); end
    for (int h = 0; h < 4; h++) begin
      step(0, 0, 1, 0, 0);
      n_cmp++; e = ev(0, 32'h20, 0, 0, 0);
      if (obs !== e) begin n_bad++; $display("FAIL hold%0d got %h exp %h", h, obs, e); end
    end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(0, 32'h20, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL hold_rel got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h24, 1, 1, 32'h20);
    if (obs !== e) begin n_bad++; $display("FAIL hold_emit got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h24, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL hold_once got %h exp %h", obs, e); end
  endtask

  task automatic test_branch_drop;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h30, 1, 1, 32'h2C);
    if (obs !== e) begin n_bad++; $display("FAIL drop_req got %h exp %h", obs, e); end
    step(0, 0, 0, 1, 32'h103);
    n_cmp++; e = ev(1, 32'h30, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL drop_br got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h30, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL drop_wait got %h exp %h", obs, e); end
    step(0, 1, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h30, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL drop_ack got %h exp %h", obs, e); end
    step(0, 1, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h100, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL drop_tgt got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h104, 1, 1, 32'h100);
    if (obs !== e) begin n_bad++; $display("FAIL drop_emit got %h exp %h", obs, e); end
  endtask

  task automatic test_branch_ack_stall;
    step(0, 1, 0, 1, 32'h40);
    n_cmp++; e = ev(1, 32'h104, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL bas_br got %h exp %h", obs, e); end
    step(0, 1, 1, 1, 32'h200);
    n_cmp++; e = ev(1, 32'h40, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL bas_ack got %h exp %h", obs, e); end
    step(0, 0, 1, 0, 0);
    n_cmp++; e = ev(1, 32'h200, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL bas_nohold got %h exp %h", obs, e); end
    step(0, 1, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h200, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL bas_ack2 got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h204, 1, 1, 32'h200);
    if (obs !== e) begin n_bad++; $display("FAIL bas_emit got %h exp %h", obs, e); end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 0, 1, 32'h300);
    n_cmp++; e = ev(1, 32'h204, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_br got %h exp %h", obs, e); end
    step(1, 0, 0, 0, 0);
    n_cmp++; e = ev(0, 32'h204, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_drop_rst got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h0, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_drop_after got %h exp %h", obs, e); end
    step(0, 1, 1, 0, 0);
    n_cmp++; e = ev(1, 32'h0, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_hold_in got %h exp %h", obs, e); end
    step(1, 0, 1, 0, 0);
    n_cmp++; e = ev(0, 32'h0, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_hold_rst got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h0, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_hold_after got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h0, 1, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL rm_nobuf got %h exp %h", obs, e); end
  endtask

  task automatic test_wrap;
    step(0, 1, 0, 1, 32'hFFFF_FFFF);
    n_cmp++; e = ev(1, 32'h0, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL wrap_br got %h exp %h", obs, e); end
    step(0, 1, 0, 0, 0);
    n_cmp++; e = ev(1, 32'hFFFF_FFFC, 0, 0, 0);
    if (obs !== e) begin n_bad++; $display("FAIL wrap_top got %h exp %h", obs, e); end
    step(0, 0, 0, 0, 0);
    n_cmp++; e = ev(1, 32'h0, 1, 1, 32'hFFFF_FFFC);
    if (obs !== e) begin n_bad++; $display("FAIL wrap_zero got %h exp %h", obs, e); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bf = 1'b0; ack = 1'b0; tgt = '0;
    test_reset();
    test_stream();
    test_slow_mem();
    test_stall_hold();
    test_branch_drop();
    test_branch_ack_stall();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
